// File: rtl/vmem_pkg.sv
// rtl/vmem_pkg.sv - shared widths, beat count and state encoding for the vector memory sequencer
package vmem_pkg;

    localparam int N      = 32;
    localparam int V      = 256;
    localparam int BEATS  = V / N;
    localparam int BEAT_W = $clog2(BEATS);

    localparam logic [N-1:0] BYTE_OFFSET = N'(4);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } vmem_state_t;

endpackage

// File: rtl/vmem_beat_sequencer.sv
// rtl/vmem_beat_sequencer.sv - serialises one 256-bit vector load/store into 32-bit memory beats
module vmem_beat_sequencer
    import vmem_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           MemReqVM,
    input  logic           MemWriteVM,
    input  logic [N-1:0]   AddrM,
    input  logic [V-1:0]   WriteDataVM,
    input  logic [N-1:0]   mem_rdata,
    input  logic           mem_ready,
    output logic           mem_valid,
    output logic           mem_we,
    output logic [N-1:0]   mem_addr,
    output logic [N-1:0]   mem_wdata,
    output logic [V-1:0]   ReadDataVM,
    output logic           StallVM,
    output logic           DoneVM
);

    vmem_state_t       state;
    logic [BEAT_W-1:0] beat;
    logic [N-1:0]      base;
    logic [V-1:0]      wbuf;
    logic [V-1:0]      rbuf;
    logic              store;
    logic              in_access;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            beat  <= '0;
            base  <= '0;
            wbuf  <= '0;
            rbuf  <= '0;
            store <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MemReqVM) begin
                        base  <= AddrM & ~(BYTE_OFFSET - N'(1));
                        wbuf  <= WriteDataVM;
                        store <= MemWriteVM;
                        beat  <= '0;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (!store) begin
                            rbuf[int'(beat)*N +: N] <= mem_rdata;
                        end
                        if (beat == BEAT_W'(BEATS - 1)) begin
                            state <= DONE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                // A request seen here belongs to the instruction now leaving M.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_access  = (state == ACCESS);
    assign mem_valid  = in_access;
    assign mem_we     = in_access & store;
    assign mem_addr   = in_access ? base + (N'(beat) * BYTE_OFFSET) : '0;
    assign mem_wdata  = in_access ? wbuf[int'(beat)*N +: N] : '0;
    // Stall in IDLE is same-cycle so the requesting instruction cannot leave M.
    assign StallVM    = rst & (in_access | ((state == IDLE) & MemReqVM));
    assign DoneVM     = (state == DONE);
    assign ReadDataVM = rbuf;

endmodule
